// File: rtl/hardwired_control_unit.sv
// Hardwired sequencer for the ALU system: two-byte fetch into IR, then a decoded execute step.
// Optional macro CU_ILLEGAL_HALT_EN: undefined opcodes halt the sequencer until Reset.
module hardwired_control_unit (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IROut,
  input  logic [3:0]  ALU_Flags,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [2:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  RF_ScrSel,
  output logic [4:0]  ALU_FunSel,
  output logic        ALU_WF,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [1:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Write,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic [1:0]  MuxCSel,
  output logic        MuxDSel,
  output logic        DR_E,
  output logic [1:0]  DR_FunSel,
  output logic [2:0]  T,
  output logic        Halted
);

  typedef enum logic [2:0] {
    S_T0 = 3'd0,
    S_T1 = 3'd1,
    S_T2 = 3'd2,
    S_T3 = 3'd3
  } t_state_e;

  localparam logic [5:0] OP_BRA  = 6'h00;
  localparam logic [5:0] OP_BNE  = 6'h01;
  localparam logic [5:0] OP_BEQ  = 6'h02;
  localparam logic [5:0] OP_INC  = 6'h05;
  localparam logic [5:0] OP_DEC  = 6'h06;
  localparam logic [5:0] OP_AND  = 6'h0C;
  localparam logic [5:0] OP_ORR  = 6'h0D;
  localparam logic [5:0] OP_XOR  = 6'h0F;
  localparam logic [5:0] OP_MOVL = 6'h12;
  localparam logic [5:0] OP_ADD  = 6'h15;

`ifdef CU_ILLEGAL_HALT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  t_state_e   r_t;
  t_state_e   w_t_next;
  logic       w_halted;
  logic       w_legal;
  logic       w_incdec;
  logic       w_taken;
  logic [5:0] w_op;
  logic       w_unused;

  // Register codes use only the low two bits; bit 2 of each field is ignored.
  assign w_op     = IROut[15:10];
  assign w_incdec = (w_op == OP_INC) || (w_op == OP_DEC);
  assign w_unused = ^{ALU_Flags[2:0], IROut[5], IROut[2]};

  function automatic logic [3:0] onehot4(input logic [1:0] code);
    return 4'b1000 >> code;
  endfunction

  // Opcode legality and branch condition (Z is ALU_Flags[3]).
  always_comb begin
    w_legal = 1'b1;
    w_taken = 1'b0;
    case (w_op)
      OP_BRA:  w_taken = 1'b1;
      OP_BNE:  w_taken = ~ALU_Flags[3];
      OP_BEQ:  w_taken = ALU_Flags[3];
      OP_INC, OP_DEC, OP_AND, OP_ORR, OP_XOR, OP_MOVL, OP_ADD: w_taken = 1'b0;
      default: w_legal = 1'b0;
    endcase
  end

  // Sequence counter register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_t <= S_T0;
    else       r_t <= w_t_next;
  end

`ifdef CU_ILLEGAL_HALT_EN
  logic r_halted;
  // Sticky halt flag, set when an undefined opcode reaches T2.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)                               r_halted <= 1'b0;
    else if ((r_t == S_T2) && !w_legal)      r_halted <= 1'b1;
    else                                     r_halted <= r_halted;
  end
  assign w_halted = r_halted;
`else
  assign w_halted = 1'b0;
`endif

  // Next-state: fetch takes two steps, INC/DEC need one extra execute step.
  always_comb begin
    w_t_next = r_t;
    if (w_halted || (HALT_EN && (r_t == S_T2) && !w_legal)) begin
      w_t_next = r_t;
    end else begin
      case (r_t)
        S_T0:    w_t_next = S_T1;
        S_T1:    w_t_next = S_T2;
        S_T2:    w_t_next = w_incdec ? S_T3 : S_T0;
        S_T3:    w_t_next = S_T0;
        default: w_t_next = S_T0;
      endcase
    end
  end

  // Control outputs; everything idles during Reset and while halted.
  always_comb begin
    RF_OutASel  = 3'b000;
    RF_OutBSel  = 3'b000;
    RF_FunSel   = 3'b000;
    RF_RegSel   = 4'b0000;
    RF_ScrSel   = 4'b0000;
    ALU_FunSel  = 5'b00000;
    ALU_WF      = 1'b0;
    ARF_OutCSel = 2'b00;
    ARF_OutDSel = 2'b00;
    ARF_FunSel  = 2'b00;
    ARF_RegSel  = 3'b000;
    IR_LH       = 1'b0;
    IR_Write    = 1'b0;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    MuxASel     = 2'b00;
    MuxBSel     = 2'b00;
    MuxCSel     = 2'b00;
    MuxDSel     = 1'b0;
    DR_E        = 1'b0;
    DR_FunSel   = 2'b00;
    if (Reset || w_halted) begin
      Mem_CS = 1'b1;
    end else begin
      case (r_t)
        S_T0, S_T1: begin
          Mem_CS     = 1'b0;
          IR_Write   = 1'b1;
          IR_LH      = (r_t == S_T1);
          ARF_RegSel = 3'b100;
          ARF_FunSel = 2'b01;
        end
        S_T2: begin
          case (w_op)
            OP_BRA, OP_BNE, OP_BEQ: begin
              MuxBSel    = w_taken ? 2'b11 : 2'b00;
              ARF_FunSel = w_taken ? 2'b10 : 2'b00;
              ARF_RegSel = w_taken ? 3'b100 : 3'b000;
            end
            OP_MOVL: begin
              MuxASel   = 2'b11;
              RF_FunSel = 3'b010;
              RF_RegSel = onehot4(IROut[9:8]);
            end
            OP_ADD, OP_AND, OP_ORR, OP_XOR, OP_INC, OP_DEC: begin
              RF_OutASel = {1'b0, IROut[4:3]};
              RF_FunSel  = 3'b010;
              RF_RegSel  = onehot4(IROut[7:6]);
              if (w_incdec) begin
                ALU_FunSel = 5'b10000;
              end else begin
                RF_OutBSel = {1'b0, IROut[1:0]};
                ALU_WF     = IROut[9];
                case (w_op)
                  OP_ADD:  ALU_FunSel = 5'b10100;
                  OP_AND:  ALU_FunSel = 5'b10111;
                  OP_ORR:  ALU_FunSel = 5'b11000;
                  default: ALU_FunSel = 5'b11001;
                endcase
              end
            end
            default: Mem_CS = 1'b1;
          endcase
        end
        S_T3: begin
          if (w_incdec) begin
            RF_FunSel = (w_op == OP_INC) ? 3'b001 : 3'b000;
            RF_RegSel = onehot4(IROut[7:6]);
          end else begin
            Mem_CS = 1'b1;
          end
        end
        default: Mem_CS = 1'b1;
      endcase
    end
  end

  assign T      = r_t;
  assign Halted = w_halted;

endmodule
